// File: rtl/rvga_mem_arbiter.sv
// Arbiter sharing one memory port between ifetch (imem) and memory-stage (dmem) requesters.
// Data requests have priority. A bounded dmem burst count guarantees that fetch makes progress.
module rvga_mem_arbiter #(
   parameter int unsigned MAX_DMEM_BURST = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        imem_v_i,
   input  logic [31:0] imem_addr_i,
   output logic [31:0] imem_data_o,
   output logic        imem_resp_v_o,
   input  logic        dmem_r_v_i,
   input  logic        dmem_w_v_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_data_i,
   output logic [31:0] dmem_data_o,
   output logic        dmem_resp_v_o,
   output logic        mem_r_v_o,
   output logic        mem_w_v_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_resp_v_i
);

   typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_e;

   localparam logic [3:0] BurstMax = 4'(MAX_DMEM_BURST);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [3:0]  burst_q, burst_d;
   logic        imem_resp_q, imem_resp_d;
   logic        dmem_resp_q, dmem_resp_d;
   logic [31:0] imem_data_q, imem_data_d;
   logic [31:0] dmem_data_q, dmem_data_d;

   logic dmem_req;
   logic imem_forced;

   assign dmem_req    = dmem_r_v_i | dmem_w_v_i;
   assign imem_forced = imem_v_i && (burst_q == BurstMax);

   // State register plus all datapath flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         burst_q     <= '0;
         imem_resp_q <= 1'b0;
         dmem_resp_q <= 1'b0;
         imem_data_q <= '0;
         dmem_data_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         burst_q     <= burst_d;
         imem_resp_q <= imem_resp_d;
         dmem_resp_q <= dmem_resp_d;
         imem_data_q <= imem_data_d;
         dmem_data_q <= dmem_data_d;
      end
   end

   // Next-state, grant capture and response registration.
   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      burst_d     = burst_q;
      imem_resp_d = 1'b0;
      dmem_resp_d = 1'b0;
      imem_data_d = imem_data_q;
      dmem_data_d = dmem_data_q;

      unique case (state_q)
         IDLE: begin
            if (dmem_req && !imem_forced) begin
               state_d = DBUSY;
               addr_d  = dmem_addr_i;
               wdata_d = dmem_data_i;
               // Read and write together resolve to a write.
               we_d    = dmem_w_v_i;
               // Below the limit here whenever imem waits, so the increment cannot overflow.
               burst_d = imem_v_i ? burst_q + 4'd1 : 4'd0;
            end else if (imem_v_i) begin
               state_d = IBUSY;
               addr_d  = imem_addr_i;
               we_d    = 1'b0;
               burst_d = '0;
            end else begin
               burst_d = '0;
            end
         end
         IBUSY: begin
            if (mem_resp_v_i) begin
               state_d     = IDLE;
               imem_resp_d = 1'b1;
               imem_data_d = mem_data_i;
            end
         end
         DBUSY: begin
            if (mem_resp_v_i) begin
               state_d     = IDLE;
               dmem_resp_d = 1'b1;
               dmem_data_d = mem_data_i;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-side strobes decode from state and latched kind only.
   always_comb begin
      mem_r_v_o = 1'b0;
      mem_w_v_o = 1'b0;
      unique case (state_q)
         IBUSY:   mem_r_v_o = 1'b1;
         DBUSY: begin
            mem_r_v_o = !we_q;
            mem_w_v_o = we_q;
         end
         default: ;
      endcase
   end

   assign mem_addr_o    = addr_q;
   assign mem_data_o    = wdata_q;
   assign imem_resp_v_o = imem_resp_q;
   assign imem_data_o   = imem_data_q;
   assign dmem_resp_v_o = dmem_resp_q;
   assign dmem_data_o   = dmem_data_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// Directed bench for rvga_mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_rvga_mem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        imem_v_i;
   logic [31:0] imem_addr_i;
   logic [31:0] imem_data_o;
   logic        imem_resp_v_o;
   logic        dmem_r_v_i;
   logic        dmem_w_v_i;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_data_i;
   logic [31:0] dmem_data_o;
   logic        dmem_resp_v_o;
   logic        mem_r_v_o;
   logic        mem_w_v_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic [31:0] mem_data_i;
   logic        mem_resp_v_i;

   int n_checks = 0;
   int n_fail   = 0;

   rvga_mem_arbiter #(.MAX_DMEM_BURST(4)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .imem_v_i      (imem_v_i),
      .imem_addr_i   (imem_addr_i),
      .imem_data_o   (imem_data_o),
      .imem_resp_v_o (imem_resp_v_o),
      .dmem_r_v_i    (dmem_r_v_i),
      .dmem_w_v_i    (dmem_w_v_i),
      .dmem_addr_i   (dmem_addr_i),
      .dmem_data_i   (dmem_data_i),
      .dmem_data_o   (dmem_data_o),
      .dmem_resp_v_o (dmem_resp_v_o),
      .mem_r_v_o     (mem_r_v_o),
      .mem_w_v_o     (mem_w_v_o),
      .mem_addr_o    (mem_addr_o),
      .mem_data_o    (mem_data_o),
      .mem_data_i    (mem_data_i),
      .mem_resp_v_i  (mem_resp_v_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // Packs the four handshake outputs for compact checks: {mem_r, mem_w, imem_resp, dmem_resp}.
   function automatic logic [31:0] strobes();
      return 32'({mem_r_v_o, mem_w_v_o, imem_resp_v_o, dmem_resp_v_o});
   endfunction

   logic [9:0] exp_seq;
   logic [9:0] got_seq;
   int         n_grants;

   initial begin
      rst_ni       = 1'b0;
      imem_v_i     = 1'b0;
      imem_addr_i  = '0;
      dmem_r_v_i   = 1'b0;
      dmem_w_v_i   = 1'b0;
      dmem_addr_i  = '0;
      dmem_data_i  = '0;
      mem_data_i   = '0;
      mem_resp_v_i = 1'b0;

      #3;
      check("rst_strobes", strobes(), 32'h0);
      check("rst_addr", mem_addr_o, 32'h0);
      check("rst_wdata", mem_data_o, 32'h0);
      check("rst_idata", imem_data_o, 32'h0);
      check("rst_ddata", dmem_data_o, 32'h0);
      tick();
      rst_ni = 1'b1;

      // Lone fetch: strobe for 3 cycles, memory answers in the third.
      imem_v_i    = 1'b1;
      imem_addr_i = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fetch_strobe", strobes(), 32'b1000);
         check("fetch_addr", mem_addr_o, 32'h0000_0100);
      end
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'h0000_0013;
      tick();
      mem_resp_v_i = 1'b0;
      imem_v_i     = 1'b0;
      check("fetch_resp", strobes(), 32'b0010);
      check("fetch_data", imem_data_o, 32'h0000_0013);
      tick();
      check("fetch_pulse_end", strobes(), 32'b0000);
      check("fetch_data_hold", imem_data_o, 32'h0000_0013);

      // Simultaneous fetch and load: the load goes first.
      imem_v_i    = 1'b1;
      imem_addr_i = 32'h0000_0104;
      dmem_r_v_i  = 1'b1;
      dmem_addr_i = 32'h0000_0200;
      tick();
      check("sim_d_strobe", strobes(), 32'b1000);
      check("sim_d_addr", mem_addr_o, 32'h0000_0200);
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'hAAAA_5555;
      tick();
      mem_resp_v_i = 1'b0;
      dmem_r_v_i   = 1'b0;
      check("sim_d_resp", strobes(), 32'b0001);
      check("sim_d_data", dmem_data_o, 32'hAAAA_5555);
      tick();
      check("sim_i_strobe", strobes(), 32'b1000);
      check("sim_i_addr", mem_addr_o, 32'h0000_0104);
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'h0000_0077;
      tick();
      mem_resp_v_i = 1'b0;
      imem_v_i     = 1'b0;
      check("sim_i_resp", strobes(), 32'b0010);
      check("sim_i_data", imem_data_o, 32'h0000_0077);
      check("sim_d_data_hold", dmem_data_o, 32'hAAAA_5555);
      tick();

      // Store held two cycles before the memory acks it.
      dmem_w_v_i  = 1'b1;
      dmem_addr_i = 32'h0000_0300;
      dmem_data_i = 32'hDEAD_BEEF;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("st_strobe", strobes(), 32'b0100);
         check("st_addr", mem_addr_o, 32'h0000_0300);
         check("st_wdata", mem_data_o, 32'hDEAD_BEEF);
      end
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'h1234_5678;
      tick();
      mem_resp_v_i = 1'b0;
      dmem_w_v_i   = 1'b0;
      check("st_resp", strobes(), 32'b0001);
      tick();
      check("st_pulse_end", strobes(), 32'b0000);

      // Spurious memory response in IDLE.
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'hFFFF_FFFF;
      tick();
      mem_resp_v_i = 1'b0;
      check("spur_strobes", strobes(), 32'b0000);
      check("spur_idata", imem_data_o, 32'h0000_0077);
      check("spur_ddata", dmem_data_o, 32'h1234_5678);

      // Read and write together are issued as a write.
      dmem_r_v_i  = 1'b1;
      dmem_w_v_i  = 1'b1;
      dmem_addr_i = 32'h0000_0400;
      dmem_data_i = 32'h0BAD_F00D;
      tick();
      check("rw_strobe", strobes(), 32'b0100);
      check("rw_wdata", mem_data_o, 32'h0BAD_F00D);
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'h0;
      tick();
      mem_resp_v_i = 1'b0;
      dmem_r_v_i   = 1'b0;
      dmem_w_v_i   = 1'b0;
      check("rw_resp", strobes(), 32'b0001);
      tick();

      // Starvation guard: both held, zero-wait memory, fetch every fifth grant.
      exp_seq     = 10'b10_0001_0000;
      got_seq     = '0;
      n_grants    = 0;
      imem_v_i    = 1'b1;
      imem_addr_i = 32'h0000_1000;
      dmem_r_v_i  = 1'b1;
      dmem_addr_i = 32'h0000_2000;
      for (int c = 0; c < 60 && n_grants < 10; c++) begin
         tick();
         mem_resp_v_i = 1'b0;
         if (mem_r_v_o || mem_w_v_o) begin
            got_seq[n_grants] = (mem_addr_o == 32'h0000_1000);
            n_grants++;
            mem_resp_v_i = 1'b1;
            mem_data_i   = 32'(c);
         end
      end
      tick();
      mem_resp_v_i = 1'b0;
      imem_v_i     = 1'b0;
      dmem_r_v_i   = 1'b0;
      check("burst_count", 32'(n_grants), 32'd10);
      for (int i = 0; i < 10; i++)
         check($sformatf("burst_grant%0d", i), 32'(got_seq[i]), 32'(exp_seq[i]));
      tick();
      tick();

      // Reset in the middle of a store.
      dmem_w_v_i  = 1'b1;
      dmem_addr_i = 32'h0000_0500;
      dmem_data_i = 32'h5555_AAAA;
      tick();
      check("mid_st_strobe", strobes(), 32'b0100);
      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_strobes", strobes(), 32'b0000);
      check("mid_rst_addr", mem_addr_o, 32'h0);
      check("mid_rst_wdata", mem_data_o, 32'h0);
      check("mid_rst_ddata", dmem_data_o, 32'h0);
      tick();
      dmem_w_v_i   = 1'b0;
      mem_resp_v_i = 1'b1;
      rst_ni       = 1'b1;
      tick();
      mem_resp_v_i = 1'b0;
      check("post_rst_strobes", strobes(), 32'b0000);
      imem_v_i    = 1'b1;
      imem_addr_i = 32'h0000_0600;
      tick();
      check("post_rst_fetch", strobes(), 32'b1000);
      check("post_rst_addr", mem_addr_o, 32'h0000_0600);
      mem_resp_v_i = 1'b1;
      mem_data_i   = 32'hCAFE_0001;
      tick();
      mem_resp_v_i = 1'b0;
      imem_v_i     = 1'b0;
      check("post_rst_resp", strobes(), 32'b0010);
      check("post_rst_idata", imem_data_o, 32'hCAFE_0001);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
